// File: rtl/pir_pkg.sv
// -----------------------------------------------------------------------------
// pir_pkg
// Shared definitions for the PIR scan controller: FSM state encoding, sensor
// and counter widths, and small helpers for the saturating alarm counter and
// the round-robin slot index.
// -----------------------------------------------------------------------------
package pir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ALARM = 2'd2
    } state_e;

    localparam int NUM_SENSORS = 3;
    localparam int SENSOR_W    = 7;
    localparam int COUNT_W     = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        logic [COUNT_W-1:0] r;
        if (v == {COUNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + COUNT_W'(1);
        end
        return r;
    endfunction

    // Slot sequence 0 -> 1 -> 2 -> 0; the unused code 3 recovers to 0.
    function automatic logic [1:0] next_slot(input logic [1:0] s);
        logic [1:0] r;
        case (s)
            2'd0:    r = 2'd1;
            2'd1:    r = 2'd2;
            2'd2:    r = 2'd0;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pir_slot_timer.sv
// -----------------------------------------------------------------------------
// pir_slot_timer
// Slot divider: counts 0..DIV-1 while enabled, wrapping to 0 after the
// terminal count. Clear has priority over enable; a disabled timer holds.
//
// Ports:
//   clk_i  - system clock, rising edge
//   rst_i  - synchronous active-high reset
//   en_i   - count enable
//   clr_i  - synchronous clear to 0 (overrides en_i)
//   tc_o   - high while the count sits at DIV-1
// -----------------------------------------------------------------------------
module pir_slot_timer #(
    parameter int DIV = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);
    import pir_pkg::*;

    localparam logic [7:0] LAST = 8'(DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tc_o = (cnt_q == LAST);

    // Next count: clear, wrap at terminal count, increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            if (tc_o) begin
                cnt_d = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pir_scan_ctrl.sv
// -----------------------------------------------------------------------------
// pir_scan_ctrl
// Round-robin scanner for three PIR sensors. While armed it samples one sensor
// every SAMPLE_DIV clocks, flags sensors at or above the threshold on LED, and
// raises the buzzer (ALARM) at the end of a full round if any flag is set.
// The alarm is acknowledged with stop_alarm; turn=0 disarms from any state.
//
// Ports:
//   clk            - system clock, rising edge
//   rst            - synchronous active-high reset
//   turn           - arm/enable; 0 forces IDLE
//   stop_alarm     - alarm acknowledge (only honoured in ALARM)
//   pir_sensor_1/2/3 - 7-bit sensor readings
//   threshold      - 7-bit trip level, sampled at capture edges only
//   sel            - current slot (0..2 = sensor 1..3)
//   sample_valid   - one-cycle pulse per captured sample
//   sample_value   - last captured reading
//   LED            - per-sensor trip flags, bit i = sensor i+1
//   buzzer         - high while in ALARM
//   alarm_count    - saturating count of ALARM entries
// -----------------------------------------------------------------------------
module pir_scan_ctrl #(
    parameter int SAMPLE_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       turn,
    input  logic       stop_alarm,
    input  logic [6:0] pir_sensor_1,
    input  logic [6:0] pir_sensor_2,
    input  logic [6:0] pir_sensor_3,
    input  logic [6:0] threshold,
    output logic [1:0] sel,
    output logic       sample_valid,
    output logic [6:0] sample_value,
    output logic [2:0] LED,
    output logic       buzzer,
    output logic [7:0] alarm_count
);
    import pir_pkg::*;

    state_e                 state_q,  state_d;
    logic [1:0]             sel_q,    sel_d;
    logic                   valid_q,  valid_d;
    logic [SENSOR_W-1:0]    value_q,  value_d;
    logic [NUM_SENSORS-1:0] led_q,    led_d;
    logic                   buzzer_q, buzzer_d;
    logic [COUNT_W-1:0]     count_q,  count_d;

    logic                   tc_s;
    logic                   timer_en_s;
    logic                   timer_clr_s;
    logic [SENSOR_W-1:0]    sensor_sel_s;
    logic                   hit_s;
    logic [NUM_SENSORS-1:0] led_cap_s;

    // The divider only runs while scanning; it restarts from 0 on every
    // entry into SCAN and holds its (already wrapped) value through ALARM.
    assign timer_en_s  = turn && (state_q == ST_SCAN);
    assign timer_clr_s = !turn || (state_q == ST_IDLE) ||
                         ((state_q == ST_ALARM) && stop_alarm);

    pir_slot_timer #(
        .DIV (SAMPLE_DIV)
    ) u_timer (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (timer_en_s),
        .clr_i (timer_clr_s),
        .tc_o  (tc_s)
    );

    // Sensor mux and the LED vector as it would look after a capture now.
    always_comb begin
        sensor_sel_s = {SENSOR_W{1'b0}};
        led_cap_s    = led_q;
        case (sel_q)
            2'd0:    sensor_sel_s = pir_sensor_1;
            2'd1:    sensor_sel_s = pir_sensor_2;
            2'd2:    sensor_sel_s = pir_sensor_3;
            default: sensor_sel_s = {SENSOR_W{1'b0}};
        endcase
        hit_s = (sensor_sel_s >= threshold);
        case (sel_q)
            2'd0:    led_cap_s[0] = hit_s;
            2'd1:    led_cap_s[1] = hit_s;
            2'd2:    led_cap_s[2] = hit_s;
            default: led_cap_s    = led_q;
        endcase
    end

    // FSM next state and next values of every registered output.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        valid_d  = 1'b0;
        value_d  = value_q;
        led_d    = led_q;
        buzzer_d = buzzer_q;
        count_d  = count_q;
        if (!turn) begin
            // Disarm wins over everything, including an acknowledge.
            state_d  = ST_IDLE;
            sel_d    = 2'd0;
            led_d    = {NUM_SENSORS{1'b0}};
            buzzer_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SCAN;
                    sel_d    = 2'd0;
                    buzzer_d = 1'b0;
                end
                ST_SCAN: begin
                    if (tc_s) begin
                        value_d = sensor_sel_s;
                        valid_d = 1'b1;
                        led_d   = led_cap_s;
                        sel_d   = next_slot(sel_q);
                        // End of a round: any flag (including this one) trips.
                        if ((sel_q == 2'd2) && (|led_cap_s)) begin
                            state_d  = ST_ALARM;
                            buzzer_d = 1'b1;
                            count_d  = sat_inc(count_q);
                        end else begin
                            state_d = ST_SCAN;
                        end
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
                ST_ALARM: begin
                    if (stop_alarm) begin
                        state_d  = ST_SCAN;
                        sel_d    = 2'd0;
                        led_d    = {NUM_SENSORS{1'b0}};
                        buzzer_d = 1'b0;
                    end else begin
                        state_d  = ST_ALARM;
                        buzzer_d = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    sel_d    = 2'd0;
                    led_d    = {NUM_SENSORS{1'b0}};
                    buzzer_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= 2'd0;
            valid_q  <= 1'b0;
            value_q  <= {SENSOR_W{1'b0}};
            led_q    <= {NUM_SENSORS{1'b0}};
            buzzer_q <= 1'b0;
            count_q  <= {COUNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            value_q  <= value_d;
            led_q    <= led_d;
            buzzer_q <= buzzer_d;
            count_q  <= count_d;
        end
    end

    assign sel          = sel_q;
    assign sample_valid = valid_q;
    assign sample_value = value_q;
    assign LED          = led_q;
    assign buzzer       = buzzer_q;
    assign alarm_count  = count_q;

endmodule

// File: doc/pir_scan_ctrl.md
PIR_SCAN_CTRL -- requirements
Module: pir_scan_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter SAMPLE_DIV SHALL default to 16, the clocks per sensor slot (legal range 2..255).
REQ-003 Port clk SHALL be: input, 1, system clock, rising edge.
REQ-004 Port rst SHALL be: input, 1, synchronous active-high reset.
REQ-005 Port turn SHALL be: input, 1, system arm/enable; 0 forces IDLE.
REQ-006 Port stop_alarm SHALL be: input, 1, alarm acknowledge, level-sampled.
REQ-007 Ports pir_sensor_1/2/3 SHALL be: input, 7 each, unsigned sensor readings.
REQ-008 Port threshold SHALL be: input, 7, unsigned trip level.
REQ-009 Port sel SHALL be: output, 2, index of the current slot (0..2 = sensor 1..3).
REQ-010 Port sample_valid SHALL be: output, 1, one-cycle pulse per captured sample.
REQ-011 Port sample_value SHALL be: output, 7, last captured reading.
REQ-012 Port LED SHALL be: output, 3, per-sensor trip flags, where bit i = sensor i+1.
REQ-013 Port buzzer SHALL be: output, 1, high in the ALARM state.
REQ-014 Port alarm_count SHALL be: output, 8, saturating count of alarm entries.

Function
REQ-015 The FSM SHALL have states IDLE, SCAN and ALARM; all outputs SHALL be registered.
REQ-016 IDLE->SCAN SHALL occur when turn=1; the slot divider and sel SHALL both start at 0.
REQ-017 In SCAN, the divider SHALL count 0..SAMPLE_DIV-1; at the edge leaving terminal count, the block SHALL:
  - capture pir_sensor[sel] into sample_value;
  - pulse sample_valid;
  - set LED[sel] = (sample >= threshold), else clear it;
  - advance sel 0->1->2->0;
  - reset the divider to 0.
REQ-018 Sample period per sensor SHALL be 3*SAMPLE_DIV clocks; sample_valid SHALL never assert outside SCAN.
REQ-019 At the slot-2 capture edge, if any LED bit (including the new slot-2 result) is 1, the state SHALL become ALARM on that same edge.
REQ-020 On ALARM entry, alarm_count SHALL increment, saturating at 255.
REQ-021 In ALARM, the block SHALL:
  - hold buzzer=1;
  - freeze LED, sel and sample_value;
  - stop the divider.
REQ-022 ALARM with stop_alarm=1 SHALL, on the next edge:
  - move to SCAN;
  - clear LED to 000;
  - set buzzer=0;
  - set sel=0 and the divider to 0.
REQ-023 stop_alarm SHALL be ignored in IDLE and SCAN.
REQ-024 turn=0 in any state SHALL, on the next edge:
  - move to IDLE;
  - clear LED, buzzer, sel and the divider;
  - retain alarm_count and sample_value.
REQ-025 When turn=0 and stop_alarm=1 occur together, turn=0 SHALL take priority (go to IDLE).
REQ-026 threshold SHALL be sampled only at capture edges; a change mid-slot SHALL affect the next capture only.

Reset
REQ-027 rst=1 SHALL set the following on the next edge, overriding all other inputs:
  - state=IDLE;
  - sel=0, divider=0;
  - sample_valid=0, sample_value=0;
  - LED=000, buzzer=0;
  - alarm_count=0.
REQ-028 Reset asserted mid-slot or in ALARM SHALL discard the partial slot and any pending alarm.

Structure
REQ-029 Shared package pir_pkg SHALL hold:
  - the state encoding (IDLE=0, SCAN=1, ALARM=2);
  - NUM_SENSORS=3;
  - SENSOR_W=7;
  - COUNT_W=8.
REQ-030 The slot divider SHALL be a sub-module, pir_slot_timer, with enable and clear inputs and a terminal-count output.

Verification (SAMPLE_DIV=4)
REQ-031 Reset: rst=1 for 2 cycles with turn=1 -> sel=0, LED=000, buzzer=0, sample_valid=0, alarm_count=0.
REQ-032 Quiet scan: turn=1, all sensors=10, threshold=64 -> sample_valid every 4 clocks, sel 0,1,2,0, sample_value=10, LED=000, buzzer=0 for 24 cycles.
REQ-033 Boundary trip: sensor_2=64, others=63, threshold=64 -> after slot-1 capture LED=010; at slot-2 capture state=ALARM, buzzer=1, alarm_count=1; with sensor_2=63 there is no trip.
REQ-034 Acknowledge: in ALARM, pulse stop_alarm=1 for one cycle -> next cycle buzzer=0, LED=000, sel=0; first new sample_valid follows 4 clocks later.
REQ-035 Disarm priority: turn=0 and stop_alarm=1 together during ALARM -> IDLE, buzzer=0, alarm_count unchanged; re-arm gives first sample 4 clocks after turn=1.
REQ-036 Saturation: force 257 alarm/acknowledge cycles -> alarm_count=255 and holds.
